// File: rtl/pi_ratio_div.sv
// pi_ratio_div: sequential restoring divider producing pi ~= 4*hits/total as unsigned fixed point.
module pi_ratio_div #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] hits,
  input  logic [WIDTH-1:0] total,
  output logic             busy,
  output logic             done,
  output logic [FRAC+2:0]  pi_q,
  output logic             div_zero,
  output logic             ovf
);
  localparam int QW = FRAC + 3;
  localparam int N  = WIDTH + FRAC + 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t           r_state, w_next;
  logic [N-1:0]     r_dvd, r_quo, w_quo_n;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem, w_rem_n;
  logic [WIDTH+1:0] w_rs;
  logic [CW-1:0]    r_cnt;
  logic [QW-1:0]    r_pi;
  logic             r_dz, r_ovf, r_zp, w_ge, w_ovf;

  assign w_rs    = {r_rem, r_dvd[N-1]};
  assign w_ge    = w_rs >= {2'b00, r_dvs};
  assign w_rem_n = w_ge ? (WIDTH+1)'(w_rs - {2'b00, r_dvs}) : (WIDTH+1)'(w_rs);
  assign w_quo_n = N'({r_quo, w_ge});
  assign w_ovf   = |w_quo_n[N-1:QW];

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;

  // A zero divisor spends one silent DIV cycle (busy masked) so its result lands one edge after start.
  always_comb
    w_next = r_state == IDLE ? (start ? DIV : IDLE) :
             r_state == DIV  ? (r_cnt == '0 ? FIN : DIV) : IDLE;

  always_comb begin
    busy = (r_state == DIV) && !r_zp;
    done = r_state == FIN;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_zp  <= 1'b0;
      r_pi  <= '0;
      r_dz  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_dvd <= {hits, {(FRAC+2){1'b0}}};
      r_dvs <= total;
      r_rem <= '0;
      r_quo <= '0;
      r_zp  <= total == '0;
      r_cnt <= total == '0 ? '0 : CW'(N-1);
    end else if (r_state == DIV) begin
      r_dvd <= r_dvd << 1;
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      else begin
        r_zp  <= 1'b0;
        r_dz  <= r_zp;
        r_ovf <= !r_zp && w_ovf;
        r_pi  <= (r_zp || w_ovf) ? '1 : w_quo_n[QW-1:0];
      end
    end

  assign pi_q     = r_pi;
  assign div_zero = r_dz;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_pi_ratio_div.sv
// tb_pi_ratio_div: randomized and directed checks of pi_ratio_div against an arithmetic reference.
module tb_pi_ratio_div;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [7:0] hits = '0, total = '0;
  logic       busy, done, div_zero, ovf;
  logic [8:0] pi_q;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pi_ratio_div #(.WIDTH(8), .FRAC(6)) dut (
    .clk(clk), .rst(rst), .start(start), .hits(hits), .total(total),
    .busy(busy), .done(done), .pi_q(pi_q), .div_zero(div_zero), .ovf(ovf)
  );

  // Returns {div_zero, ovf, pi_q} from plain integer arithmetic.
  function automatic logic [10:0] model(int h, int t);
    int q;
    if (t == 0) return {2'b10, 9'h1FF};
    q = h * 256 / t;
    if (q > 511) return {2'b01, 9'h1FF};
    return {2'b00, 9'(q)};
  endfunction

  task automatic do_div(input int h, input int t, output logic [10:0] r,
                        output int lat, output int bc, output bit to);
    @(posedge clk); #1;
    @(negedge clk); hits = 8'(h); total = 8'(t); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 1; bc = 0; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin to = 1'b0; break; end
      bc += int'(busy);
      @(posedge clk); #1; lat++;
    end
    r = {div_zero, ovf, pi_q};
  endtask

  task automatic test_reset;
    logic [10:0] r; int lat, bc; bit to;
    repeat (3) @(posedge clk);
    #1; checks++;
    if ({busy, done, pi_q, div_zero, ovf} !== 13'h0) begin errors++; $display("FAIL reset_init: got %b want 0", {busy, done, pi_q, div_zero, ovf}); end
    @(negedge clk); rst = 1'b1;
    do_div(255, 1, r, lat, bc, to);
    @(posedge clk); #1;
    @(negedge clk); hits = 8'd9; total = 8'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1; checks++;
    if ({busy, done, pi_q, div_zero, ovf} !== 13'h0) begin errors++; $display("FAIL reset_mid_div: got %b want 0", {busy, done, pi_q, div_zero, ovf}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bc = 0;
    repeat (20) begin @(posedge clk); #1; bc += int'(done); end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL reset_no_done: got %0d done pulses want 0", bc); end
    do_div(100, 100, r, lat, bc, to);
    checks++;
    if (to || r !== {2'b00, 9'h100} || lat !== 17) begin errors++; $display("FAIL reset_after: got r=%h lat=%0d to=%0d want r=100 lat=17", r, lat, to); end
  endtask

  task automatic test_nominal;
    logic [10:0] r; int lat, bc; bit to;
    do_div(200, 255, r, lat, bc, to);
    checks++;
    if (to || r !== model(200, 255)) begin errors++; $display("FAIL nominal_result: got %h want %h", r, model(200, 255)); end
    checks++;
    if (bc !== 16 || lat !== 17) begin errors++; $display("FAIL nominal_timing: got busy=%0d lat=%0d want 16/17", bc, lat); end
    @(posedge clk); #1; checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL nominal_done_width: got done=%b want 0", done); end
  endtask

  task automatic test_second;
    logic [10:0] r; int lat, bc; bit to;
    do_div(157, 200, r, lat, bc, to);
    checks++;
    if (to || r !== {2'b00, 9'd200}) begin errors++; $display("FAIL second_157_200: got %h want %h", r, {2'b00, 9'd200}); end
    do_div(0, 37, r, lat, bc, to);
    checks++;
    if (to || r !== 11'h0) begin errors++; $display("FAIL second_0_37: got %h want 0", r); end
  endtask

  task automatic test_div_zero;
    logic [10:0] r; int lat, bc; bit to;
    do_div(5, 0, r, lat, bc, to);
    checks++;
    if (to || r !== {2'b10, 9'h1FF}) begin errors++; $display("FAIL dz_result: got %h want %h", r, {2'b10, 9'h1FF}); end
    checks++;
    if (lat !== 2 || bc !== 0) begin errors++; $display("FAIL dz_timing: got lat=%0d busy=%0d want 2/0", lat, bc); end
    do_div(50, 100, r, lat, bc, to);
    checks++;
    if (to || r !== {2'b00, 9'd128}) begin errors++; $display("FAIL dz_clear: got %h want %h", r, {2'b00, 9'd128}); end
  endtask

  task automatic test_overflow;
    logic [10:0] r; int lat, bc; bit to;
    do_div(255, 1, r, lat, bc, to);
    checks++;
    if (to || r !== {2'b01, 9'h1FF}) begin errors++; $display("FAIL ovf_set: got %h want %h", r, {2'b01, 9'h1FF}); end
    do_div(64, 128, r, lat, bc, to);
    checks++;
    if (to || r !== {2'b00, 9'd128}) begin errors++; $display("FAIL ovf_clear: got %h want %h", r, {2'b00, 9'd128}); end
  endtask

  task automatic test_handshake;
    int nd = 0;
    bit to = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); hits = 8'd157; total = 8'd200; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 3) begin start = 1'b1; hits = 8'd255; total = 8'd0; end
      if (k == 7) start = 1'b0;
      if (done) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (to || {div_zero, ovf, pi_q} !== {2'b00, 9'd200}) begin errors++; $display("FAIL hs_result: got %h to=%0d want %h", {div_zero, ovf, pi_q}, to, {2'b00, 9'd200}); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hs_fin_start: got done=%b busy=%b want 0/0", done, busy); end
    repeat (20) begin @(posedge clk); #1; nd += int'(done); end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL hs_extra_done: got %0d want 0", nd); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] r; int lat, bc; bit to;
    do_div(10, 20, r, lat, bc, to);
    checks++;
    if (to || r !== model(10, 20)) begin errors++; $display("FAIL b2b_first: got %h want %h", r, model(10, 20)); end
    do_div(64, 128, r, lat, bc, to);
    checks++;
    if (to || r !== model(64, 128) || lat !== 17) begin errors++; $display("FAIL b2b_second: got %h lat=%0d want %h lat=17", r, lat, model(64, 128)); end
  endtask

  task automatic test_random;
    logic [10:0] r; int lat, bc, h, t; bit to;
    for (int i = 0; i < 30; i++) begin
      h = int'($urandom_range(0, 255));
      t = (i % 7 == 0) ? 0 : int'($urandom_range(1, 255));
      do_div(h, t, r, lat, bc, to);
      checks++;
      if (to || r !== model(h, t) || lat !== (t == 0 ? 2 : 17)) begin
        errors++;
        $display("FAIL random h=%0d t=%0d: got %h lat=%0d want %h lat=%0d", h, t, r, lat, model(h, t), t == 0 ? 2 : 17);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_second();
    test_div_zero();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
